// File: rtl/net2axis_master_player.sv
// AXI4-Stream master that replays a preloaded packet trace: metadata entries carry
// inter-packet delay or end-of-stream, data entries map directly onto M_AXIS.
module net2axis_master_player #(
  parameter int    C_TDATA_WIDTH = 32,
  parameter int    C_DEPTH       = 256,
  parameter int    C_DELAY_WIDTH = 16,
  parameter string C_INITFILE    = ""
) (
  input  logic                                         ACLK,
  input  logic                                         ARESET,
  input  logic                                         LOAD_EN,
  input  logic [$clog2(C_DEPTH)-1:0]                   LOAD_ADDR,
  input  logic [C_TDATA_WIDTH+C_TDATA_WIDTH/8+1:0]     LOAD_DATA,
  input  logic                                         START,
  output logic                                         M_AXIS_TVALID,
  output logic [C_TDATA_WIDTH-1:0]                     M_AXIS_TDATA,
  output logic [C_TDATA_WIDTH/8-1:0]                   M_AXIS_TKEEP,
  output logic                                         M_AXIS_TLAST,
  input  logic                                         M_AXIS_TREADY,
  output logic                                         DONE,
  output logic                                         ERR,
  output logic [15:0]                                  PKT_CNT
);

  localparam int KW = C_TDATA_WIDTH / 8;
  localparam int EW = C_TDATA_WIDTH + KW + 2;
  localparam int AW = $clog2(C_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(C_DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ_MD, S_DELAY, S_STREAM, S_FINISH} state_e;

  logic [EW-1:0]            mem_q [C_DEPTH];
  state_e                   state_q, state_d;
  logic [AW-1:0]            ptr_q, ptr_d;
  logic [C_DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0]              pkt_cnt_q, pkt_cnt_d;
  logic                     err_q, err_d;
  logic                     done_q, done_d;

  logic [EW-1:0]            entry;
  logic                     e_md, e_last, at_end, beat_valid;
  logic [KW-1:0]            e_keep;
  logic [C_TDATA_WIDTH-1:0] e_data;
  logic [C_DELAY_WIDTH-1:0] e_delay;

  assign entry      = mem_q[ptr_q];
  assign e_md       = entry[EW-1];
  assign e_last     = entry[EW-2];
  assign e_keep     = entry[EW-3 -: KW];
  assign e_data     = entry[C_TDATA_WIDTH-1:0];
  assign e_delay    = entry[C_DELAY_WIDTH-1:0];
  assign at_end     = (ptr_q == LAST_ADDR);
  // A metadata entry reached while streaming is a format error, never a beat.
  assign beat_valid = (state_q == S_STREAM) && !e_md;

  // NOTE: the trace memory has no reset so it maps onto plain RAM and survives ARESET.
  always_ff @(posedge ACLK) begin
    if (LOAD_EN && (state_q == S_IDLE || state_q == S_FINISH)) begin
      mem_q[LOAD_ADDR] <= LOAD_DATA;
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    err_d     = err_q;
    done_d    = done_q;
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (START) begin
          state_d   = S_READ_MD;
          ptr_d     = '0;
          pkt_cnt_d = '0;
          err_d     = 1'b0;
          done_d    = 1'b0;
        end
      end
      S_READ_MD: begin
        if (!e_md) begin
          err_d   = 1'b1;
          state_d = S_STREAM;
        end else if (e_last || at_end) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + AW'(1);
          if (e_delay == '0) begin
            state_d = S_STREAM;
          end else begin
            cnt_d   = e_delay;
            state_d = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        cnt_d = cnt_q - C_DELAY_WIDTH'(1);
        if (cnt_q <= C_DELAY_WIDTH'(1)) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (e_md) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else if (M_AXIS_TREADY) begin
          if (e_last && pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
          if (at_end) begin
            // Running off the end of memory mid-packet leaves a truncated packet.
            err_d   = err_q | ~e_last;
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + AW'(1);
            if (e_last) state_d = S_READ_MD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign M_AXIS_TVALID = beat_valid;
  assign M_AXIS_TDATA  = beat_valid ? e_data : '0;
  assign M_AXIS_TKEEP  = beat_valid ? e_keep : '0;
  assign M_AXIS_TLAST  = beat_valid & e_last;
  assign DONE          = done_q;
  assign ERR           = err_q;
  assign PKT_CNT       = pkt_cnt_q;

endmodule

// File: tb/tb_net2axis_master_player.sv
// Bench for net2axis_master_player: traces are replayed and every beat, gap and
// status output is compared against a trace-walking reference model.
module tb_net2axis_master_player;

  localparam int DW    = 32;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 32;
  localparam int DLYW  = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int EW    = DW + KW + 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            gap;
  } beat_t;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          LOAD_EN = 1'b0;
  logic [AW-1:0] LOAD_ADDR = '0;
  logic [EW-1:0] LOAD_DATA = '0;
  logic          START = 1'b0;
  logic          M_AXIS_TVALID;
  logic [DW-1:0] M_AXIS_TDATA;
  logic [KW-1:0] M_AXIS_TKEEP;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TREADY = 1'b0;
  logic          DONE;
  logic          ERR;
  logic [15:0]   PKT_CNT;

  int n_checks = 0;
  int n_pass   = 0;

  logic [EW-1:0] trace [DEPTH];
  beat_t         exp_q [$];
  int            exp_pkts;
  logic          exp_err;

  net2axis_master_player #(
    .C_TDATA_WIDTH(DW), .C_DEPTH(DEPTH), .C_DELAY_WIDTH(DLYW), .C_INITFILE("")
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR),
    .LOAD_DATA(LOAD_DATA), .START(START), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY), .DONE(DONE), .ERR(ERR), .PKT_CNT(PKT_CNT)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] mk_md(input logic eos, input int d);
    return {1'b1, eos, {KW{1'b0}}, DW'(d)};
  endfunction

  function automatic logic [EW-1:0] mk_data(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                            input logic last);
    return {1'b0, last, k, d};
  endfunction

  task automatic clear_trace();
    for (int i = 0; i < DEPTH; i++) trace[i] = mk_md(1'b1, 0);
  endtask

  task automatic load_trace();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge ACLK);
      LOAD_EN = 1'b1; LOAD_ADDR = AW'(i); LOAD_DATA = trace[i];
    end
    @(negedge ACLK);
    LOAD_EN = 1'b0;
  endtask

  // Walks the trace as a list of packets: metadata, then beats up to LAST.
  // Each expected beat carries the number of idle (TVALID=0) cycles before it.
  task automatic model_run();
    int            i = 0;
    int            gap = 0;
    bit            stop = 0;
    logic [EW-1:0] e;
    exp_q.delete();
    exp_pkts = 0;
    exp_err  = 1'b0;
    while (!stop) begin
      e = trace[i];
      gap += 1;
      if (e[EW-1]) begin
        if (e[EW-2]) break;
        gap += int'(e[DLYW-1:0]);
        i++;
        if (i == DEPTH) break;
      end else begin
        exp_err = 1'b1;
      end
      forever begin
        e = trace[i];
        if (e[EW-1]) begin exp_err = 1'b1; stop = 1; break; end
        exp_q.push_back('{data: e[DW-1:0], keep: e[DW+KW-1:DW], last: e[EW-2], gap: gap});
        gap = 0;
        i++;
        if (e[EW-2]) begin
          exp_pkts++;
          if (i == DEPTH) stop = 1;
          break;
        end
        if (i == DEPTH) begin exp_err = 1'b1; stop = 1; break; end
      end
    end
  endtask

  // mode 0: TREADY=1; mode 1: random TREADY; mode 2: TREADY follows 1,0,0,1 per offered beat.
  task automatic replay(input string name, input int mode, output logic first_err);
    beat_t         b;
    int            cyc = 0, gap = 0, pi = 0;
    logic          rdy, pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [KW-1:0] pk = '0;
    logic [3:0]    pat = 4'b1001;
    first_err = 1'bx;
    model_run();
    @(negedge ACLK); START = 1'b1;
    @(negedge ACLK); START = 1'b0;
    while (DONE !== 1'b1 && cyc < 3000) begin
      if (cyc == 1) first_err = ERR;
      if (pv && !pr) begin
        n_checks++;
        if ({M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST} !== {pv, pd, pk, pl})
          $display("FAIL %s_hold: got v=%b d=%h k=%h l=%b, required v=1 d=%h k=%h l=%b",
                   name, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, pd, pk, pl);
        else n_pass++;
      end
      if (M_AXIS_TVALID !== 1'b1) begin
        n_checks++;
        if ({M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST} !== '0)
          $display("FAIL %s_idle_zero: got d=%h k=%h l=%b, required all 0",
                   name, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST);
        else n_pass++;
        gap++;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: begin rdy = pat[pi % 4]; if (M_AXIS_TVALID === 1'b1) pi++; end
      endcase
      M_AXIS_TREADY = rdy;
      if (M_AXIS_TVALID === 1'b1 && rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s_extra_beat: got d=%h, required no beat", name, M_AXIS_TDATA);
        end else begin
          b = exp_q.pop_front();
          if (M_AXIS_TDATA !== b.data || M_AXIS_TKEEP !== b.keep || M_AXIS_TLAST !== b.last ||
              gap != b.gap)
            $display("FAIL %s_beat: got d=%h k=%h l=%b gap=%0d, required d=%h k=%h l=%b gap=%0d",
                     name, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, gap,
                     b.data, b.keep, b.last, b.gap);
          else n_pass++;
        end
        gap = 0;
      end
      pv = M_AXIS_TVALID; pr = rdy; pd = M_AXIS_TDATA; pk = M_AXIS_TKEEP; pl = M_AXIS_TLAST;
      @(negedge ACLK);
      cyc++;
    end
    n_checks++;
    if (cyc >= 3000) $display("FAIL %s_timeout: DONE not seen within 3000 cycles", name);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s_missing: got %0d beats short, required 0",
                                    name, exp_q.size());
    else n_pass++;
    n_checks++;
    if (PKT_CNT !== 16'(exp_pkts) || ERR !== exp_err || DONE !== 1'b1)
      $display("FAIL %s_status: got pkt=%0d err=%b done=%b, required pkt=%0d err=%b done=1",
               name, PKT_CNT, ERR, DONE, exp_pkts, exp_err);
    else n_pass++;
    M_AXIS_TREADY = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ACLK);
    n_checks++;
    if ({M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, DONE, ERR, PKT_CNT} !== '0)
      $display("FAIL reset_outputs: got v=%b d=%h k=%h l=%b done=%b err=%b pkt=%0d, required all 0",
               M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, DONE, ERR, PKT_CNT);
    else n_pass++;
    ARESET = 1'b0;
    @(negedge ACLK);
    n_checks++;
    if (M_AXIS_TVALID !== 1'b0 || DONE !== 1'b0)
      $display("FAIL reset_idle: got v=%b done=%b, required 0 0", M_AXIS_TVALID, DONE);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic fe;
    clear_trace();
    trace[0] = mk_md(1'b0, 0);
    trace[1] = mk_data(32'hA0A1A2A3, 4'hF, 1'b0);
    trace[2] = mk_data(32'hB0B1B2B3, 4'h3, 1'b1);
    load_trace();
    replay("basic", 0, fe);
  endtask

  task automatic test_delay();
    logic fe;
    clear_trace();
    trace[0] = mk_md(1'b0, 0);
    trace[1] = mk_data(32'hCAFE0001, 4'hF, 1'b1);
    trace[2] = mk_md(1'b0, 5);
    trace[3] = mk_data(32'hCAFE0002, 4'hF, 1'b1);
    load_trace();
    replay("delay", 0, fe);
  endtask

  task automatic test_backpressure();
    logic fe;
    clear_trace();
    trace[0] = mk_md(1'b0, 2);
    for (int b = 0; b < 3; b++) trace[1+b] = mk_data(32'h5EED0000 + DW'(b), 4'hF, b == 2);
    load_trace();
    replay("backpressure", 2, fe);
  endtask

  task automatic test_no_md();
    logic fe;
    clear_trace();
    trace[0] = mk_data(32'h0BADF00D, 4'hF, 1'b1);
    load_trace();
    replay("no_md", 0, fe);
    n_checks++;
    if (fe !== 1'b1) $display("FAIL no_md_err_early: got ERR=%b in first STREAM cycle, required 1", fe);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int   guard = 0;
    logic fe;
    clear_trace();
    trace[0] = mk_md(1'b0, 0);
    for (int b = 0; b < 4; b++) trace[1+b] = mk_data(32'hA5000000 + DW'(b), 4'hF, b == 3);
    load_trace();
    M_AXIS_TREADY = 1'b1;
    @(negedge ACLK); START = 1'b1;
    @(negedge ACLK); START = 1'b0;
    while (M_AXIS_TVALID !== 1'b1 && guard < 20) begin @(negedge ACLK); guard++; end
    @(negedge ACLK);
    n_checks++;
    if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== 32'hA5000001)
      $display("FAIL rst_mid_beat2: got v=%b d=%h, required v=1 d=a5000001",
               M_AXIS_TVALID, M_AXIS_TDATA);
    else n_pass++;
    #2 ARESET = 1'b1;
    #1;
    n_checks++;
    if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0 || PKT_CNT !== 16'd0 || DONE !== 1'b0)
      $display("FAIL rst_mid_async: got v=%b l=%b pkt=%0d done=%b, required 0 0 0 0",
               M_AXIS_TVALID, M_AXIS_TLAST, PKT_CNT, DONE);
    else n_pass++;
    @(negedge ACLK); ARESET = 1'b0;
    replay("rst_mid_replay", 0, fe);
  endtask

  task automatic test_load_in_stream();
    int   guard = 0;
    logic fe;
    clear_trace();
    trace[0] = mk_md(1'b0, 0);
    trace[1] = mk_data(32'h11223344, 4'hF, 1'b1);
    load_trace();
    M_AXIS_TREADY = 1'b0;
    @(negedge ACLK); START = 1'b1;
    @(negedge ACLK); START = 1'b0;
    while (M_AXIS_TVALID !== 1'b1 && guard < 20) begin @(negedge ACLK); guard++; end
    LOAD_EN = 1'b1; LOAD_ADDR = AW'(1); LOAD_DATA = mk_data(32'hDEADBEEF, 4'h1, 1'b0);
    @(negedge ACLK); LOAD_EN = 1'b0;
    n_checks++;
    if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== 32'h11223344)
      $display("FAIL load_in_stream_hold: got v=%b d=%h, required v=1 d=11223344",
               M_AXIS_TVALID, M_AXIS_TDATA);
    else n_pass++;
    M_AXIS_TREADY = 1'b1;
    guard = 0;
    while (DONE !== 1'b1 && guard < 50) begin @(negedge ACLK); guard++; end
    n_checks++;
    if (DONE !== 1'b1) $display("FAIL load_in_stream_done: got DONE=%b, required 1", DONE);
    else n_pass++;
    replay("load_in_stream_mem", 0, fe);
  endtask

  task automatic test_random();
    logic fe;
    int   idx, nb;
    for (int it = 0; it < 6; it++) begin
      clear_trace();
      idx = 0;
      for (int p = 0; p < 4; p++) begin
        trace[idx++] = mk_md(1'b0, int'($urandom_range(0, 4)));
        nb = int'($urandom_range(1, 4));
        for (int b = 0; b < nb; b++)
          trace[idx++] = mk_data($urandom, KW'($urandom_range(1, 15)),
                                 (b == nb - 1) && !(it == 3 && p == 1));
      end
      load_trace();
      replay($sformatf("random%0d", it), 1, fe);
    end
  endtask

  task automatic test_mem_end();
    logic fe;
    trace[0] = mk_md(1'b0, 0);
    for (int i = 1; i < DEPTH; i++) trace[i] = mk_data($urandom, 4'hF, 1'b0);
    load_trace();
    replay("mem_end", 1, fe);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_backpressure();
    test_no_md();
    test_reset_mid();
    test_load_in_stream();
    test_random();
    test_mem_end();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
